// File: rtl/result_bcd_formatter.sv
// Sequential binary-to-BCD formatter for the signed 16-bit ALU result (double-dabble, one bit per cycle).
// Latency: done pulses 17 edges after the start edge (18th cycle counting the start cycle); outputs then hold.
// Backpressure: none; start is honoured only in IDLE, and starts seen while busy are dropped, not queued.
//
// Ports:
//   clk, rst            - clock (rising edge), asynchronous active-high reset
//   result[15:0]        - signed ALU result, two's complement
//   opcode[1:0]         - ALU opcode; 2'b11 marks a scaled-division result (decimal point lit)
//   start               - request conversion of result/opcode
//   busy                - conversion in progress (start edge through the DONE state)
//   done                - one-cycle pulse, bcd/neg/dp/blank freshly updated
//   bcd[19:0]           - five BCD digits, [19:16] ten-thousands ... [3:0] ones
//   neg                 - result was negative
//   dp                  - decimal point between digit 2 and digit 1
//   blank[4:0]          - per-digit blank mask; leading-zero blanking is built only when
//                         FORMATTER_LEADING_BLANK_EN is defined, otherwise tied to zero
module result_bcd_formatter (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] result,
    input  logic [1:0]  opcode,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [19:0] bcd,
    output logic        neg,
    output logic        dp,
    output logic [4:0]  blank
);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] mag_q, mag_d;          // magnitude being shifted out MSB first
    logic [19:0] scratch_q, scratch_d;  // BCD accumulator
    logic [4:0]  cnt_q, cnt_d;          // shifts remaining
    logic        neg_n_q, neg_n_d;      // captured sign, published in DONE
    logic        dp_n_q, dp_n_d;        // captured decimal-point flag
    logic [19:0] bcd_q, bcd_d;
    logic        neg_q, neg_d;
    logic        dp_q, dp_d;
    logic        done_q, done_d;
    logic [19:0] adj;                   // scratch after the add-3 correction

    // Add 3 to every digit >= 5 so that the following left shift carries correctly into the next digit.
    function automatic logic [19:0] add3(input logic [19:0] s);
        logic [19:0] r;
        r = s;
        for (int i = 0; i < 5; i++) begin
            if (s[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = s[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    assign adj = add3(scratch_q);

    always_comb begin
        state_d   = state_q;
        mag_d     = mag_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        neg_n_d   = neg_n_q;
        dp_n_d    = dp_n_q;
        bcd_d     = bcd_q;
        neg_d     = neg_q;
        dp_d      = dp_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    neg_n_d   = result[15];
                    // Two's-complement negate; -32768 wraps to 16'h8000 = 32768 unsigned.
                    mag_d     = result[15] ? (~result + 16'd1) : result;
                    dp_n_d    = (opcode == 2'b11);
                    scratch_d = 20'd0;
                    cnt_d     = 5'd16;
                    state_d   = CONV;
                end
            end
            CONV: begin
                // Top digit never reaches 5 because the magnitude is at most 32768.
                {scratch_d, mag_d} = {adj, mag_q} << 1;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d   = scratch_q;
                neg_d   = neg_n_q;
                dp_d    = dp_n_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mag_q     <= 16'd0;
            scratch_q <= 20'd0;
            cnt_q     <= 5'd0;
            neg_n_q   <= 1'b0;
            dp_n_q    <= 1'b0;
            bcd_q     <= 20'd0;
            neg_q     <= 1'b0;
            dp_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mag_q     <= mag_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            neg_n_q   <= neg_n_d;
            dp_n_q    <= dp_n_d;
            bcd_q     <= bcd_d;
            neg_q     <= neg_d;
            dp_q      <= dp_d;
            done_q    <= done_d;
        end
    end

`ifdef FORMATTER_LEADING_BLANK_EN
    logic [4:0] blank_q, blank_d;
    logic [4:0] lead_blank;
    logic       zero_above;

    // Walk down from the top digit; a digit is blanked while it and everything above it is zero.
    // Digit 0 is never blanked, and with the decimal point lit digits 0-2 always show (5 -> 0.05).
    always_comb begin
        lead_blank = 5'b00000;
        zero_above = 1'b1;
        for (int i = 4; i >= 1; i--) begin
            zero_above    = zero_above & (scratch_q[4*i +: 4] == 4'd0);
            lead_blank[i] = zero_above & ~(dp_n_q && (i <= 2));
        end
    end

    always_comb begin
        blank_d = blank_q;
        if (state_q == DONE) begin
            blank_d = lead_blank;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blank_q <= 5'b11110;
        end else begin
            blank_q <= blank_d;
        end
    end

    assign blank = blank_q;
`else
    assign blank = 5'b00000;
`endif

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign bcd  = bcd_q;
    assign neg  = neg_q;
    assign dp   = dp_q;

endmodule

// File: tb/tb_result_bcd_formatter.sv
module tb_result_bcd_formatter;

    logic        clk;
    logic        rst;
    logic [15:0] result;
    logic [1:0]  opcode;
    logic        start;
    logic        busy;
    logic        done;
    logic [19:0] bcd;
    logic        neg;
    logic        dp;
    logic [4:0]  blank;

    result_bcd_formatter dut (
        .clk    (clk),
        .rst    (rst),
        .result (result),
        .opcode (opcode),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .bcd    (bcd),
        .neg    (neg),
        .dp     (dp),
        .blank  (blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [19:0] bcd;
        logic        neg;
        logic        dp;
        logic [4:0]  blank;
        int          t0;
    } exp_t;

    exp_t sb[$];

    // Stimulus-side and monitor-side counters are kept apart so each process owns its own.
    int s_pass = 0, s_tot = 0;
    int m_pass = 0, m_tot = 0;

    task automatic s_chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        s_tot++;
        if (act === exp) s_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic m_chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        m_tot++;
        if (act === exp) m_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Expected blank mask: the hand-computed leading-zero mask when blanking is built, else zero.
    function automatic logic [4:0] blk(input logic [4:0] m);
`ifdef FORMATTER_LEADING_BLANK_EN
        return m;
`else
        return 5'b00000 & m;
`endif
    endfunction

    // Monitor: every done pulse pops one expectation and compares fields and latency.
    initial begin
        exp_t e;
        logic prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_done = 1'b0;
            end else begin
                if (done) begin
                    m_chk("done_single_cycle", {31'd0, prev_done}, 32'd0);
                    m_chk("done_expected", {31'd0, (sb.size() != 0)}, 32'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        m_chk("bcd", {12'd0, bcd}, {12'd0, e.bcd});
                        m_chk("neg", {31'd0, neg}, {31'd0, e.neg});
                        m_chk("dp", {31'd0, dp}, {31'd0, e.dp});
                        m_chk("blank", {27'd0, blank}, {27'd0, e.blank});
                        m_chk("latency", cyc - e.t0, 32'd18);
                        m_chk("busy_low_with_done", {31'd0, busy}, 32'd0);
                    end
                end
                prev_done = done;
            end
        end
    end

    // Issue one start pulse at a negedge; the sampling posedge follows half a cycle later.
    task automatic issue(input logic [15:0] r, input logic [1:0] op, input logic [19:0] eb,
                         input logic en, input logic ed, input logic [4:0] ebl);
        exp_t e;
        @(negedge clk);
        result = r;
        opcode = op;
        start  = 1'b1;
        e.bcd = eb; e.neg = en; e.dp = ed; e.blank = blk(ebl); e.t0 = cyc;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        s_chk("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 60) begin
            @(posedge clk);
            k++;
        end
        @(negedge clk);
        s_chk("drain_timeout", sb.size(), 32'd0);
    endtask

    initial begin
        rst = 1'b1; result = 16'd0; opcode = 2'b00; start = 1'b0;
        repeat (3) @(negedge clk);
        s_chk("rst_busy", {31'd0, busy}, 32'd0);
        s_chk("rst_done", {31'd0, done}, 32'd0);
        s_chk("rst_bcd", {12'd0, bcd}, 32'd0);
        s_chk("rst_neg_dp", {30'd0, neg, dp}, 32'd0);
        s_chk("rst_blank", {27'd0, blank}, {27'd0, blk(5'b11110)});
        rst = 1'b0;
        @(negedge clk);

        issue(16'd1234,  2'b00, 20'h01234, 1'b0, 1'b0, 5'b10000); drain();
        issue(16'h8000,  2'b00, 20'h32768, 1'b1, 1'b0, 5'b00000); drain();
        issue(-16'sd12800, 2'b11, 20'h12800, 1'b1, 1'b1, 5'b00000); drain();
        issue(16'd5,     2'b11, 20'h00005, 1'b0, 1'b1, 5'b11000); drain();
        issue(16'd0,     2'b00, 20'h00000, 1'b0, 1'b0, 5'b11110); drain();
        issue(16'd9999,  2'b01, 20'h09999, 1'b0, 1'b0, 5'b10000); drain();
        issue(16'hFFFF,  2'b11, 20'h00001, 1'b1, 1'b1, 5'b11000); drain();

        // A second start mid-conversion must be dropped.
        issue(16'd99,    2'b00, 20'h00099, 1'b0, 1'b0, 5'b11100);
        repeat (3) @(negedge clk);
        result = 16'd42; opcode = 2'b00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (25) @(negedge clk);
        s_chk("no_extra_done", sb.size(), 32'd0);
        s_chk("idle_after_ignored", {31'd0, busy}, 32'd0);

        // Reset mid-conversion: outputs return to reset values and no done follows.
        @(negedge clk);
        result = 16'd777; opcode = 2'b11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        s_chk("abort_busy", {31'd0, busy}, 32'd0);
        s_chk("abort_done", {31'd0, done}, 32'd0);
        s_chk("abort_bcd", {12'd0, bcd}, 32'd0);
        s_chk("abort_neg_dp", {30'd0, neg, dp}, 32'd0);
        s_chk("abort_blank", {27'd0, blank}, {27'd0, blk(5'b11110)});
        rst = 1'b0;
        repeat (30) @(negedge clk);
        s_chk("abort_no_done_busy", {31'd0, busy}, 32'd0);
        s_chk("abort_bcd_hold", {12'd0, bcd}, 32'd0);

        // Converter still works after the abort.
        issue(16'd300, 2'b00, 20'h00300, 1'b0, 1'b0, 5'b11000); drain();

        $display("%0d/%0d checks passed", s_pass + m_pass, s_tot + m_tot);
        $finish;
    end

endmodule
